// File: rtl/ps2_host_cmd_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_cmd_if
// Brief    : Command handshake, PS/2 line and receiver signals of the
//            PS/2 host command sequencer, bundled for port connection.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_host_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_byte;
  logic       cmd_has_arg;
  logic [7:0] cmd_arg;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       rx_enable;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
    input  ps2_clk_in, ps2_data_in, rx_valid, rx_byte,
    output cmd_ready, ps2_clk_oe, ps2_data_oe, rx_enable, done, err, err_code
  );

  // Command issuer / line environment side
  modport master (
    output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
    output ps2_clk_in, ps2_data_in, rx_valid, rx_byte,
    input  cmd_ready, ps2_clk_oe, ps2_data_oe, rx_enable, done, err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/ps2_host_cmd.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_cmd
// Brief    : PS/2 host-to-device command sequencer. Inhibits the bus,
//            issues request-to-send, clocks out one or two bytes under
//            device clocking, checks the line ack and collects FA/FE replies
//            with bounded resends.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_cmd #(
  parameter int unsigned INHIBIT_CYCLES      = 5000,
  parameter int unsigned BIT_TIMEOUT_CYCLES  = 100000,
  parameter int unsigned RESP_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY           = 2
) (
  input  logic          clk,
  input  logic          resetn,
  ps2_host_cmd_if.slave bus
);

  // One shared counter serves the inhibit window and both timeouts, so it is
  // sized for the largest of the three limits.
  localparam int unsigned c_MAX_AB = (INHIBIT_CYCLES > BIT_TIMEOUT_CYCLES) ?
                                     INHIBIT_CYCLES : BIT_TIMEOUT_CYCLES;
  localparam int unsigned c_MAX    = (c_MAX_AB > RESP_TIMEOUT_CYCLES) ?
                                     c_MAX_AB : RESP_TIMEOUT_CYCLES;
  localparam int c_CW = $clog2(c_MAX + 1);
  localparam int c_RW = $clog2(MAX_RETRY + 2);

  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0] c_INH_LAST = c_CW'(INHIBIT_CYCLES - 1);
  localparam logic [c_CW-1:0] c_BIT_LAST = c_CW'(BIT_TIMEOUT_CYCLES - 1);
  localparam logic [c_CW-1:0] c_RSP_LAST = c_CW'(RESP_TIMEOUT_CYCLES - 1);
  localparam logic [c_RW-1:0] c_RTY_MAX  = c_RW'(MAX_RETRY);
  localparam logic [c_RW-1:0] c_RTY_ONE  = c_RW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_RTS     = 3'd2,
    S_SEND    = 3'd3,
    S_LACK    = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t          r_state;
  logic [7:0]      r_cmd_byte;
  logic            r_has_arg;
  logic [7:0]      r_arg;
  logic            r_sel;
  logic [c_RW-1:0] r_retry;
  logic [c_CW-1:0] r_cnt;
  logic [3:0]      r_bitn;
  logic            r_prev;
  logic            r_cmd_ready;
  logic            r_clk_oe;
  logic            r_data_oe;
  logic            r_rx_en;
  logic            r_done;
  logic            r_err;
  logic [1:0]      r_err_code;

  logic            w_fall;
  logic [7:0]      w_cur;
  logic [9:0]      w_frame;
  logic            w_fail;
  logic [1:0]      w_code;

  assign w_fall  = r_prev & ~bus.ps2_clk_in;
  assign w_cur   = r_sel ? r_arg : r_cmd_byte;
  // Stop bit, odd parity, data LSB first
  assign w_frame = {1'b1, ~^w_cur, w_cur};

  // Decide whether the current cycle aborts the command, and why
  always_comb begin
    w_fail = 1'b0;
    w_code = 2'd0;
    case (r_state)
      S_SEND: begin
        if (!w_fall && r_cnt == c_BIT_LAST) begin
          w_fail = 1'b1;
          w_code = 2'd1;
        end
      end
      S_LACK: begin
        if (w_fall) begin
          if (bus.ps2_data_in) begin
            w_fail = 1'b1;
            w_code = 2'd2;
          end
        end else if (r_cnt == c_BIT_LAST) begin
          w_fail = 1'b1;
          w_code = 2'd1;
        end
      end
      S_RESP: begin
        // A byte arriving on the timeout cycle takes precedence
        if (bus.rx_valid) begin
          if ((bus.rx_byte == 8'hFE && r_retry >= c_RTY_MAX) ||
              (bus.rx_byte != 8'hFE && bus.rx_byte != 8'hFA)) begin
            w_fail = 1'b1;
            w_code = 2'd3;
          end
        end else if (r_cnt == c_RSP_LAST) begin
          w_fail = 1'b1;
          w_code = 2'd3;
        end
      end
      default: begin
        w_fail = 1'b0;
        w_code = 2'd0;
      end
    endcase
  end

  // Sequencer FSM with registered line drives and status pulses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cmd_byte  <= 8'h00;
      r_has_arg   <= 1'b0;
      r_arg       <= 8'h00;
      r_sel       <= 1'b0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_bitn      <= 4'd0;
      r_prev      <= 1'b1;
      r_cmd_ready <= 1'b1;
      r_clk_oe    <= 1'b0;
      r_data_oe   <= 1'b0;
      r_rx_en     <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_prev <= bus.ps2_clk_in;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_fail) begin
        r_clk_oe    <= 1'b0;
        r_data_oe   <= 1'b0;
        r_err       <= 1'b1;
        r_err_code  <= w_code;
        r_cmd_ready <= 1'b1;
        r_rx_en     <= 1'b1;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.cmd_valid && r_cmd_ready) begin
              r_cmd_byte  <= bus.cmd_byte;
              r_has_arg   <= bus.cmd_has_arg;
              r_arg       <= bus.cmd_arg;
              r_sel       <= 1'b0;
              r_retry     <= '0;
              r_cnt       <= '0;
              r_clk_oe    <= 1'b1;
              r_data_oe   <= 1'b0;
              r_rx_en     <= 1'b0;
              r_cmd_ready <= 1'b0;
              r_state     <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (r_cnt == c_INH_LAST) begin
              r_data_oe <= 1'b1;
              r_state   <= S_RTS;
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
          S_RTS: begin
            // Start bit stays driven; the device now owns the clock
            r_clk_oe <= 1'b0;
            r_cnt    <= '0;
            r_bitn   <= 4'd0;
            r_state  <= S_SEND;
          end
          S_SEND: begin
            if (w_fall) begin
              r_cnt     <= '0;
              r_data_oe <= ~w_frame[r_bitn];
              r_bitn    <= r_bitn + 4'd1;
              if (r_bitn == 4'd9) begin
                r_state <= S_LACK;
              end
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
          S_LACK: begin
            if (w_fall) begin
              r_cnt   <= '0;
              r_rx_en <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
          S_RESP: begin
            if (bus.rx_valid) begin
              if (bus.rx_byte == 8'hFE) begin
                r_retry  <= r_retry + c_RTY_ONE;
                r_cnt    <= '0;
                r_clk_oe <= 1'b1;
                r_rx_en  <= 1'b0;
                r_state  <= S_INHIBIT;
              end else if (!r_sel && r_has_arg) begin
                r_sel    <= 1'b1;
                r_retry  <= '0;
                r_cnt    <= '0;
                r_clk_oe <= 1'b1;
                r_rx_en  <= 1'b0;
                r_state  <= S_INHIBIT;
              end else begin
                r_done      <= 1'b1;
                r_cmd_ready <= 1'b1;
                r_state     <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.ps2_clk_oe  = r_clk_oe;
  assign bus.ps2_data_oe = r_data_oe;
  assign bus.rx_enable   = r_rx_en;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.err_code    = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_cmd
// Brief    : Self-checking bench for ps2_host_cmd with a PS/2 device model
//            and a reply-sequence reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_cmd;
  localparam int INH = 40;
  localparam int BTO = 300;
  localparam int RTO = 1500;
  localparam int MR  = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic last_rx_en;
  logic [7:0] m_bytes[$];
  logic [9:0] frames[$];
  logic [7:0] rq[$];

  ps2_host_cmd_if bus();

  // Open-drain lines: either side can pull low
  assign bus.ps2_clk_in  = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

  ps2_host_cmd #(
    .INHIBIT_CYCLES(INH), .BIT_TIMEOUT_CYCLES(BTO),
    .RESP_TIMEOUT_CYCLES(RTO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse counters
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run did not end, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Expected line bits for a byte: data LSB first, odd parity, stop
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // Reference: which bytes go on the wire and how the command ends
  task automatic model_run(input logic [7:0] rep[$], input logic [7:0] c, input bit ha,
                           input logic [7:0] a, output bit ok, output int code);
    int idx;
    int retry;
    idx = 0; retry = 0; ok = 0; code = 0;
    m_bytes.delete();
    foreach (rep[i]) begin
      m_bytes.push_back(idx == 0 ? c : a);
      if (rep[i] == 8'hFA) begin
        if (idx == 0 && ha) begin idx = 1; retry = 0; end
        else begin ok = 1; return; end
      end else if (rep[i] == 8'hFE && retry < MR) begin
        retry++;
      end else begin
        code = 3; return;
      end
    end
    code = 3;
  endtask

  task automatic issue_cmd(input logic [7:0] c, input bit ha, input logic [7:0] a);
    int t;
    t = 0;
    while (!bus.cmd_ready && t < 5000) begin @(negedge clk); t++; end
    bus.cmd_byte = c; bus.cmd_has_arg = ha; bus.cmd_arg = a;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Device side of one host frame: watch inhibit/RTS, then clock out edges
  task automatic dev_frame(input int edges, output int inh, output logic [9:0] seen,
                           output bit ok, output bit rx_low);
    int t;
    ok = 1; inh = 0; seen = '0; rx_low = 0; t = 0;
    while (!(bus.ps2_clk_oe && !bus.ps2_data_oe) && t < 3000) begin @(negedge clk); t++; end
    while (bus.ps2_clk_oe && !bus.ps2_data_oe && t < 6000) begin inh++; @(negedge clk); t++; end
    while (bus.ps2_clk_oe && t < 6000) begin @(negedge clk); t++; end
    if (t >= 6000 || !bus.ps2_data_oe) begin ok = 0; return; end
    rx_low = !bus.rx_enable;
    for (int k = 0; k < edges; k++) begin
      repeat ($urandom_range(2, 6)) @(negedge clk);
      dev_clk = 1'b0;
      repeat ($urandom_range(2, 6)) @(negedge clk);
      seen[k] = ~bus.ps2_data_oe;
      dev_clk = 1'b1;
    end
  endtask

  task automatic dev_ack(input bit low);
    repeat (3) @(negedge clk);
    dev_data = low ? 1'b0 : 1'b1;
    repeat (2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (3) @(negedge clk);
    dev_clk = 1'b1;
    dev_data = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_reply(input logic [7:0] b);
    repeat ($urandom_range(2, 5)) @(negedge clk);
    last_rx_en = bus.rx_enable;
    bus.rx_byte = b; bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_result(input int limit, output bit gd, output bit ge,
                             output logic [1:0] gc, output int n);
    n = 0;
    while (!bus.done && !bus.err && n < limit) begin @(negedge clk); n++; end
    gd = bus.done; ge = bus.err; gc = bus.err_code;
  endtask

  // Full command against the reference model, reply sequence given in rep
  task automatic run_sequence(input string name, input logic [7:0] c, input bit ha,
                              input logic [7:0] a, input logic [7:0] rep[$]);
    bit exp_ok; int exp_code; int inh; logic [9:0] seen; bit fok; bit rxl;
    bit gd; bit ge; logic [1:0] gc; int n; int d0; int e0;
    model_run(rep, c, ha, a, exp_ok, exp_code);
    frames.delete();
    d0 = done_cnt; e0 = err_cnt;
    issue_cmd(c, ha, a);
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL %s ready_drop: got %b want 0", name, bus.cmd_ready); end
    foreach (m_bytes[i]) begin
      dev_frame(10, inh, seen, fok, rxl);
      dev_ack(1'b1);
      checks++;
      if (!fok || inh != INH || !rxl) begin
        errors++; $display("FAIL %s inhibit[%0d]: ok=%b len=%0d rx_low=%b want 1/%0d/1", name, i, fok, inh, rxl, INH);
      end
      checks++;
      if (seen !== ref_frame(m_bytes[i])) begin
        errors++; $display("FAIL %s frame[%0d]: got %b want %b", name, i, seen, ref_frame(m_bytes[i]));
      end
      frames.push_back(seen);
      send_reply(rep[i]);
      checks++;
      if (last_rx_en !== 1'b1) begin errors++; $display("FAIL %s rx_enable[%0d]: got %b want 1", name, i, last_rx_en); end
    end
    wait_result(RTO + 100, gd, ge, gc, n);
    checks++;
    if (gd !== exp_ok || ge !== !exp_ok) begin
      errors++; $display("FAIL %s outcome: done=%b err=%b want done=%b", name, gd, ge, exp_ok);
    end
    if (!exp_ok) begin
      checks++;
      if (int'(gc) != exp_code) begin errors++; $display("FAIL %s err_code: got %0d want %0d", name, gc, exp_code); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 != (exp_ok ? 1 : 0) || err_cnt - e0 != (exp_ok ? 0 : 1)) begin
      errors++; $display("FAIL %s pulses: done=%0d err=%0d want ok=%b", name, done_cnt - d0, err_cnt - e0, exp_ok);
    end
    checks++;
    if (bus.ps2_clk_oe || bus.ps2_data_oe || !bus.cmd_ready) begin
      errors++; $display("FAIL %s idle: clk_oe=%b data_oe=%b ready=%b want 0/0/1", name, bus.ps2_clk_oe, bus.ps2_data_oe, bus.cmd_ready);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rx_enable !== 1'b1) begin
      errors++; $display("FAIL reset_ready: ready=%b rx_en=%b want 1/1", bus.cmd_ready, bus.rx_enable);
    end
    checks++;
    if (bus.ps2_clk_oe !== 1'b0 || bus.ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL reset_oe: clk_oe=%b data_oe=%b want 0/0", bus.ps2_clk_oe, bus.ps2_data_oe);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.err_code !== 2'd0) begin
      errors++; $display("FAIL reset_status: done=%b err=%b code=%0d want 0/0/0", bus.done, bus.err, bus.err_code);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cmd_with_arg();
    rq.delete(); rq.push_back(8'hFA); rq.push_back(8'hFA);
    run_sequence("led_cmd", 8'hED, 1'b1, 8'h02, rq);
    checks++;
    if (frames.size() != 2) begin errors++; $display("FAIL led_frames: got %0d want 2", frames.size()); end
    else begin
      checks++;
      if (frames[0] !== 10'b1_1_11101101 || frames[1] !== 10'b1_0_00000010) begin
        errors++; $display("FAIL led_bits: got %b %b want 1111101101 1000000010", frames[0], frames[1]);
      end
    end
  endtask

  task automatic test_resend();
    rq.delete(); rq.push_back(8'hFE); rq.push_back(8'hFA);
    run_sequence("resend", 8'hFF, 1'b0, 8'h00, rq);
    checks++;
    if (frames.size() != 2 || frames[0] !== frames[1]) begin
      errors++; $display("FAIL resend_identical: frames=%0d want 2 equal", frames.size());
    end
  endtask

  task automatic test_retry_exhaust();
    rq.delete(); rq.push_back(8'hFE); rq.push_back(8'hFE); rq.push_back(8'hFE);
    run_sequence("exhaust", 8'hF4, 1'b0, 8'h00, rq);
    checks++;
    if (frames.size() != 3) begin errors++; $display("FAIL exhaust_tx: got %0d want 3", frames.size()); end
  endtask

  task automatic test_no_clock();
    int inh; logic [9:0] seen; bit fok; bit rxl; bit gd; bit ge; logic [1:0] gc; int n;
    issue_cmd(8'hF2, 1'b0, 8'h00);
    dev_frame(0, inh, seen, fok, rxl);
    wait_result(BTO + 50, gd, ge, gc, n);
    checks++;
    if (!ge || gc !== 2'd1 || n != BTO) begin
      errors++; $display("FAIL no_clock: err=%b code=%0d cycles=%0d want 1/1/%0d", ge, gc, n, BTO);
    end
    checks++;
    if (bus.ps2_clk_oe || bus.ps2_data_oe) begin
      errors++; $display("FAIL no_clock_release: clk_oe=%b data_oe=%b want 0/0", bus.ps2_clk_oe, bus.ps2_data_oe);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_no_ack();
    int inh; logic [9:0] seen; bit fok; bit rxl; int e0;
    e0 = err_cnt;
    issue_cmd(8'hF3, 1'b1, 8'h20);
    bus.cmd_byte = 8'h55; bus.cmd_has_arg = 1'b0; bus.cmd_valid = 1'b1;
    dev_frame(10, inh, seen, fok, rxl);
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", bus.cmd_ready); end
    checks++;
    if (seen !== ref_frame(8'hF3)) begin errors++; $display("FAIL busy_frame: got %b want %b", seen, ref_frame(8'hF3)); end
    bus.cmd_valid = 1'b0;
    dev_ack(1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (err_cnt - e0 != 1 || bus.err_code !== 2'd2) begin
      errors++; $display("FAIL no_ack: errs=%0d code=%0d want 1/2", err_cnt - e0, bus.err_code);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (bus.ps2_clk_oe || !bus.cmd_ready) begin
      errors++; $display("FAIL not_queued: clk_oe=%b ready=%b want 0/1", bus.ps2_clk_oe, bus.cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int inh; logic [9:0] seen; bit fok; bit rxl; int d0; int e0;
    d0 = done_cnt; e0 = err_cnt;
    issue_cmd(8'hF5, 1'b0, 8'h00);
    dev_frame(4, inh, seen, fok, rxl);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ps2_clk_oe || bus.ps2_data_oe || !bus.cmd_ready) begin
      errors++; $display("FAIL mid_reset: clk_oe=%b data_oe=%b ready=%b want 0/0/1", bus.ps2_clk_oe, bus.ps2_data_oe, bus.cmd_ready);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL mid_reset_pulses: done=%0d err=%0d want 0/0", done_cnt - d0, err_cnt - e0);
    end
    rq.delete(); rq.push_back(8'hFA);
    run_sequence("after_reset", 8'hEE, 1'b0, 8'h00, rq);
  endtask

  task automatic test_resp_timeout();
    int inh; logic [9:0] seen; bit fok; bit rxl; bit gd; bit ge; logic [1:0] gc; int n; int d0;
    issue_cmd(8'hF6, 1'b0, 8'h00);
    dev_frame(10, inh, seen, fok, rxl);
    dev_ack(1'b1);
    wait_result(RTO + 50, gd, ge, gc, n);
    checks++;
    if (!ge || gc !== 2'd3 || n != RTO - 3) begin
      errors++; $display("FAIL resp_timeout: err=%b code=%0d cycles=%0d want 1/3/%0d", ge, gc, n + 3, RTO);
    end
    // Reply strobes while idle must not produce a completion
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    send_reply(8'hFA);
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != d0 || !bus.cmd_ready) begin
      errors++; $display("FAIL idle_rx: done=%0d ready=%b want 0/1", done_cnt - d0, bus.cmd_ready);
    end
  endtask

  task automatic test_random();
    logic [7:0] c; logic [7:0] a; logic [7:0] o; bit ha; int r;
    for (int it = 0; it < 5; it++) begin
      c = 8'($urandom); a = 8'($urandom); ha = 1'($urandom);
      rq.delete();
      for (int j = 0; j < 10; j++) begin
        r = int'($urandom_range(0, 9));
        o = 8'($urandom);
        if (o == 8'hFA || o == 8'hFE) o = 8'h00;
        rq.push_back(r < 6 ? 8'hFA : (r < 9 ? 8'hFE : o));
      end
      run_sequence("random", c, ha, a, rq);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_byte = 8'h00; bus.cmd_has_arg = 1'b0; bus.cmd_arg = 8'h00;
    bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
    last_rx_en = 1'b0;
    test_reset();
    test_cmd_with_arg();
    test_resend();
    test_retry_exhaust();
    test_no_clock();
    test_no_ack();
    test_reset_mid();
    test_resp_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ps2_host_cmd.md
# ps2_host_cmd

Host-to-device command sequencer for the PS/2 keyboard port. It accepts a one- or two-byte command (e.g. 0xED + LED mask, 0xFF reset) and gates the keyboard's clock and data lines open-drain to transmit each byte. It then collects the device's 0xFA/0xFE reply from the existing PS/2 receiver, retrying on resend. The block sits beside the receiver in the 50 MHz keyboard domain and owns the bus while a command is in flight.

## Interface
- INHIBIT_CYCLES, 5000: cycles the clock line is held low before request-to-send (100 µs at 50 MHz).
- BIT_TIMEOUT_CYCLES, 100000: maximum cycles between device clock falling edges (2 ms).
- RESP_TIMEOUT_CYCLES, 1000000: maximum cycles to wait for a reply byte (20 ms).
- MAX_RETRY, 2: resends allowed per byte after 0xFE.

Ports:
- clk  in  1  keyboard-domain clock.
- resetn  in  1  reset; one clock; reset is synchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_byte  in  8  first byte.
- cmd_has_arg  in  1  a second byte follows.
- cmd_arg  in  8  second byte.
- ps2_clk_in  in  1  debounced, synchronized PS/2 clock.
- ps2_data_in  in  1  synchronized PS/2 data.
- ps2_clk_oe  out  1  1 = pull clock line low.
- ps2_data_oe  out  1  1 = pull data line low.
- rx_enable  out  1  receiver allowed to capture; low from INHIBIT through LACK.
- rx_valid  in  1  receiver byte strobe, one cycle.
- rx_byte  in  8  received byte.
- done  out  1  one-cycle pulse: command fully acknowledged.
- err  out  1  one-cycle pulse: command aborted.
- err_code  out  2  valid with err: 1 clock timeout, 2 no line ack, 3 bad/missing reply or retries exhausted; holds until the next err.

## Operation
- States: IDLE, INHIBIT, RTS, SEND, LACK, RESP.
- IDLE: outputs released, rx_enable=1. When cmd_valid and cmd_ready, latch cmd_byte/cmd_has_arg/cmd_arg, select byte 0, clear the retry count, and go to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
- RTS: one cycle with clk_oe=1 and data_oe=1 (start bit). Then SEND with clk_oe=0 and data_oe held at 1.
- Frame: {stop=1, parity, d7..d0}, sent LSB first. Parity is odd: the XOR of the data bits, inverted.
- SEND: falling-edge detect on ps2_clk_in, previous-value register reset to 1. On falling edge k (k=1..10), ps2_data_oe = ~frame[k-1] from the next cycle. Edge 10 releases data (stop bit), then go to LACK.
- LACK: on the next falling edge, sample ps2_data_in. If 0, go to RESP; if 1, error code 2.
- RESP: rx_enable=1.
  - rx_byte 0xFA: if byte 0 and has_arg, select the arg, clear the retry count, and go to INHIBIT. Otherwise pulse done and go to IDLE.
  - 0xFE: if retry count < MAX_RETRY, increment it and go to INHIBIT with the same byte; otherwise error code 3.
  - Any other byte, or timeout: error code 3.
- Timeouts:
  - The bit counter restarts at every falling edge and on entry to SEND.
  - Exceeding BIT_TIMEOUT_CYCLES in SEND or LACK gives error code 1.
  - RESP timeout counts from RESP entry.
- Error path: release both lines, pulse err, go to IDLE, all in the same transition.

## Timing
- Reset values: state IDLE, cmd_ready=1, ps2_clk_oe=0, ps2_data_oe=0, rx_enable=1, done=0, err=0, err_code=0, counters 0.
- Reset asserted mid-transaction releases both lines on the next clk edge; no done or err pulse.
- cmd_ready drops the cycle after acceptance. cmd_valid while busy is ignored, not queued.
- Output pins are registered; line changes lag the detected edge by one cycle.
- rx_valid outside RESP is ignored.
- rx_valid in the same cycle as RESP timeout: the byte wins.
- done/err assert one cycle after the deciding event; cmd_ready returns in that same cycle.
- Counters must be wide enough for RESP_TIMEOUT_CYCLES; no wrap.

## Test plan
- Send 0xED with arg 0x02, device model clocks and acks, replies FA, FA:
  - two INHIBIT windows of 5000 cycles each;
  - ~data_oe sequence per frame is 1,0,1,1,0,1,1,1 + parity 1, and 0,1,0,0,0,0,0,0 + parity 0;
  - exactly one done, no err.
- Send 0xFF, device replies FE then FA: byte retransmitted identically once, then done.
- Device replies FE three times (MAX_RETRY=2): three transmissions, then err with err_code=3.
- Device never clocks after RTS: err with err_code=1 exactly BIT_TIMEOUT_CYCLES after RTS exit; both oe outputs 0.
- Device leaves data high at the ack edge: err with err_code=2; assert cmd_valid during SEND and check the command is not accepted (cmd_ready=0).
- Assert resetn=0 after the fourth falling edge: next cycle both oe=0, state IDLE, no pulses; a new command then completes normally.
